rv32i_ctrl_decode: RTL and testbench
====================================

// Module: rv32i_ctrl_decode
// PURPOSE
//  Combined RV32I field extractor and main control unit for the single-cycle core. Splits the
//  fetched instruction into opcode/funct3/funct7 and drives datapath selects (PC source, ALU
//  operands/op, register writeback, memory access) from them and the ALU compare flags.
//  Uses the typepkg enums. Adds a sticky illegal-instruction flag for the trap/debug logic.
// PARAMETERS
//  none
// PORTS
//  clk          in   1   core clock; one clock domain
//  rst          in   1   synchronous, active-high reset
//  insn         in   32  current instruction word
//  alu_zero     in   1   ALU result == 0 (rs1-rs2 compare)
//  alu_less     in   1   rs1 < rs2, signed
//  alu_uless    in   1   rs1 < rs2, unsigned
//  opcode       out  7   insn[6:0]
//  funct3       out  3   insn[14:12]
//  funct7       out  7   insn[31:25]
//  pc_src       out  pc_src_t     PC_SRC_PC4 / PC_SRC_ALU / PC_SRC_BRANCH (pc+imm adder)
//  alu_src_a    out  alu_src_a_t  ALU_SRC_A_RS1 / ALU_SRC_A_PC
//  alu_src_b    out  alu_src_b_t  ALU_SRC_B_RS2 / ALU_SRC_B_IMM
//  alu_op       out  alu_op_t     ADD SUB AND OR XOR SLL SRL SRA SLT SLTU COPY_B
//  reg_write    out  1   rd write enable
//  reg_wb_src   out  reg_wb_src_t REG_WB_SRC_ALU / _MEM / _PC4
//  mem_write    out  mem_write_t  NONE / BYTE / HALF / WORD
//  mem_read     out  mem_read_t   NONE / BYTE / HALF / WORD / BYTE_U / HALF_U
//  illegal      out  1   current insn is not a supported encoding (combinational)
//  illegal_seen out  1   sticky: set the cycle after any illegal insn, cleared only by rst
// BEHAVIOUR
//  - All outputs except illegal_seen are purely combinational from insn/flags; zero latency.
//  - Defaults: pc_src PC4, a RS1, b RS2, op ADD, reg_write 0, wb ALU, mem NONE/NONE.
//  - OP-IMM (0010011): b IMM, reg_write 1; funct3 000 ADD,010 SLT,011 SLTU,100 XOR,110 OR,
//    111 AND, 001 SLL (funct7 must be 0), 101 SRL (funct7 0) / SRA (funct7 0100000).
//  - OP (0110011): b RS2, reg_write 1; same funct3 map, funct7 0100000 selects SUB (000)
//    / SRA (101); any other funct7 except 0 is illegal.
//  - LUI (0110111): b IMM, op COPY_B, reg_write 1. AUIPC (0010111): a PC, b IMM, ADD, reg_write 1.
//  - LOAD (0000011): b IMM, ADD, reg_write 1, wb MEM; funct3 000 BYTE,001 HALF,010 WORD,
//    100 BYTE_U,101 HALF_U; else illegal.
//  - STORE (0100011): b IMM, ADD, reg_write 0, wb ALU; funct3 000 BYTE,001 HALF,010 WORD.
//  - JAL (1101111): a PC, b IMM, ADD, pc_src ALU, reg_write 1, wb PC4.
//  - JALR (1100111, funct3 000): a RS1, b IMM, ADD, pc_src ALU, reg_write 1, wb PC4.
//  - BRANCH (1100011): a RS1, b RS2, SUB, reg_write 0; taken -> PC_SRC_BRANCH else PC4.
//    BEQ zero, BNE !zero, BLT less, BGE !less, BLTU uless, BGEU !uless; funct3 010/011 illegal.
//  - FENCE (0001111), SYSTEM (1110011): NOP (defaults), not illegal.
//  - Any other opcode or flagged funct combo: illegal=1, all defaults (no writes, PC4).
//  - illegal_seen: rst=1 at posedge -> 0; else posedge with illegal=1 -> 1; holds otherwise.
// TESTING
//  - 0x14d28393 addi -> PC4,RS1,IMM,ADD,rw1,wb ALU,mem NONE/NONE,illegal 0.
//  - 0xfd634f93 xori -> XOR, IMM, rw1; 0x00309497 auipc -> a PC,IMM,ADD,rw1.
//  - 0xff806237 lui -> IMM,COPY_B,rw1; 0x14a0a0a3 sw -> RS1,IMM,ADD,rw0,wb ALU,mem_write WORD.
//  - 0x084003ef jal -> pc_src ALU, a PC, IMM, ADD, rw1, wb PC4.
//  - 0x00208463 beq: zero=1 -> PC_SRC_BRANCH, SUB, RS2, rw0; zero=0 -> PC4.
//  - 0xffffffff -> illegal=1, rw0, mem NONE; next posedge illegal_seen=1; rst posedge -> 0.

Source files
------------

// File: rtl/rv32i_ctrl_decode.sv
// RV32I field extractor and main control unit for the single-cycle core, plus a
// sticky illegal-instruction flag consumed by the trap/debug logic.

package typepkg;
  typedef enum logic [1:0] {PC_SRC_PC4, PC_SRC_ALU, PC_SRC_BRANCH} pc_src_t;
  typedef enum logic {ALU_SRC_A_RS1, ALU_SRC_A_PC} alu_src_a_t;
  typedef enum logic {ALU_SRC_B_RS2, ALU_SRC_B_IMM} alu_src_b_t;
  typedef enum logic [3:0] {
    ALU_OP_ADD, ALU_OP_SUB, ALU_OP_AND, ALU_OP_OR, ALU_OP_XOR, ALU_OP_SLL,
    ALU_OP_SRL, ALU_OP_SRA, ALU_OP_SLT, ALU_OP_SLTU, ALU_OP_COPY_B
  } alu_op_t;
  typedef enum logic [1:0] {REG_WB_SRC_ALU, REG_WB_SRC_MEM, REG_WB_SRC_PC4} reg_wb_src_t;
  typedef enum logic [1:0] {
    MEM_WRITE_NONE, MEM_WRITE_BYTE, MEM_WRITE_HALF, MEM_WRITE_WORD
  } mem_write_t;
  typedef enum logic [2:0] {
    MEM_READ_NONE, MEM_READ_BYTE, MEM_READ_HALF, MEM_READ_WORD,
    MEM_READ_BYTE_U, MEM_READ_HALF_U
  } mem_read_t;
endpackage

module rv32i_ctrl_decode
  import typepkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] insn,
  input  logic        alu_zero,
  input  logic        alu_less,
  input  logic        alu_uless,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output pc_src_t     pc_src,
  output alu_src_a_t  alu_src_a,
  output alu_src_b_t  alu_src_b,
  output alu_op_t     alu_op,
  output logic        reg_write,
  output reg_wb_src_t reg_wb_src,
  output mem_write_t  mem_write,
  output mem_read_t   mem_read,
  output logic        illegal,
  output logic        illegal_seen
);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] F7_ZERO    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  logic unused_fields;
  logic taken;

  assign opcode = insn[6:0];
  assign funct3 = insn[14:12];
  assign funct7 = insn[31:25];
  assign unused_fields = ^{insn[24:15], insn[11:7]};

  // Shared funct3 -> ALU op map for OP and OP-IMM; alt selects SUB/SRA.
  function automatic alu_op_t arith_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  arith_op = alt ? ALU_OP_SUB : ALU_OP_ADD;
      3'b001:  arith_op = ALU_OP_SLL;
      3'b010:  arith_op = ALU_OP_SLT;
      3'b011:  arith_op = ALU_OP_SLTU;
      3'b100:  arith_op = ALU_OP_XOR;
      3'b101:  arith_op = alt ? ALU_OP_SRA : ALU_OP_SRL;
      3'b110:  arith_op = ALU_OP_OR;
      default: arith_op = ALU_OP_AND;
    endcase
  endfunction

  always_comb begin
    case (funct3)
      3'b000:  taken = alu_zero;
      3'b001:  taken = !alu_zero;
      3'b100:  taken = alu_less;
      3'b101:  taken = !alu_less;
      3'b110:  taken = alu_uless;
      3'b111:  taken = !alu_uless;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    pc_src     = PC_SRC_PC4;
    alu_src_a  = ALU_SRC_A_RS1;
    alu_src_b  = ALU_SRC_B_RS2;
    alu_op     = ALU_OP_ADD;
    reg_write  = 1'b0;
    reg_wb_src = REG_WB_SRC_ALU;
    mem_write  = MEM_WRITE_NONE;
    mem_read   = MEM_READ_NONE;
    illegal    = 1'b0;
    case (opcode)
      OPC_OP_IMM: begin
        alu_src_b = ALU_SRC_B_IMM;
        reg_write = 1'b1;
        alu_op    = arith_op(funct3, (funct3 == 3'b101) && (funct7 == F7_ALT));
        if (funct3 == 3'b001 && funct7 != F7_ZERO) illegal = 1'b1;
        if (funct3 == 3'b101 && funct7 != F7_ZERO && funct7 != F7_ALT) illegal = 1'b1;
      end
      OPC_OP: begin
        reg_write = 1'b1;
        alu_op    = arith_op(funct3, funct7 == F7_ALT);
        if (funct7 == F7_ALT) begin
          if (funct3 != 3'b000 && funct3 != 3'b101) illegal = 1'b1;
        end else if (funct7 != F7_ZERO) begin
          illegal = 1'b1;
        end
      end
      OPC_LUI: begin
        alu_src_b = ALU_SRC_B_IMM;
        alu_op    = ALU_OP_COPY_B;
        reg_write = 1'b1;
      end
      OPC_AUIPC: begin
        alu_src_a = ALU_SRC_A_PC;
        alu_src_b = ALU_SRC_B_IMM;
        reg_write = 1'b1;
      end
      OPC_LOAD: begin
        alu_src_b  = ALU_SRC_B_IMM;
        reg_write  = 1'b1;
        reg_wb_src = REG_WB_SRC_MEM;
        case (funct3)
          3'b000:  mem_read = MEM_READ_BYTE;
          3'b001:  mem_read = MEM_READ_HALF;
          3'b010:  mem_read = MEM_READ_WORD;
          3'b100:  mem_read = MEM_READ_BYTE_U;
          3'b101:  mem_read = MEM_READ_HALF_U;
          default: illegal  = 1'b1;
        endcase
      end
      OPC_STORE: begin
        alu_src_b = ALU_SRC_B_IMM;
        case (funct3)
          3'b000:  mem_write = MEM_WRITE_BYTE;
          3'b001:  mem_write = MEM_WRITE_HALF;
          3'b010:  mem_write = MEM_WRITE_WORD;
          default: illegal   = 1'b1;
        endcase
      end
      OPC_JAL: begin
        pc_src     = PC_SRC_ALU;
        alu_src_a  = ALU_SRC_A_PC;
        alu_src_b  = ALU_SRC_B_IMM;
        reg_write  = 1'b1;
        reg_wb_src = REG_WB_SRC_PC4;
      end
      OPC_JALR: begin
        pc_src     = PC_SRC_ALU;
        alu_src_b  = ALU_SRC_B_IMM;
        reg_write  = 1'b1;
        reg_wb_src = REG_WB_SRC_PC4;
        if (funct3 != 3'b000) illegal = 1'b1;
      end
      OPC_BRANCH: begin
        alu_op = ALU_OP_SUB;
        pc_src = taken ? PC_SRC_BRANCH : PC_SRC_PC4;
        if (funct3 == 3'b010 || funct3 == 3'b011) illegal = 1'b1;
      end
      OPC_FENCE, OPC_SYSTEM: ;
      default: illegal = 1'b1;
    endcase
    // An illegal encoding must never write state or redirect the PC.
    if (illegal) begin
      pc_src     = PC_SRC_PC4;
      alu_src_a  = ALU_SRC_A_RS1;
      alu_src_b  = ALU_SRC_B_RS2;
      alu_op     = ALU_OP_ADD;
      reg_write  = 1'b0;
      reg_wb_src = REG_WB_SRC_ALU;
      mem_write  = MEM_WRITE_NONE;
      mem_read   = MEM_READ_NONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      illegal_seen <= 1'b0;
    end else if (illegal) begin
      illegal_seen <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rv32i_ctrl_decode.sv
// Directed table-driven bench for rv32i_ctrl_decode with hand-written
// sequences for the sticky illegal_seen flag.

module tb_rv32i_ctrl_decode;
  import typepkg::*;

  typedef struct packed {
    pc_src_t     pc_src;
    alu_src_a_t  a;
    alu_src_b_t  b;
    alu_op_t     op;
    logic        rw;
    reg_wb_src_t wb;
    mem_write_t  mw;
    mem_read_t   mr;
    logic        ill;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
  } out_t;

  typedef struct {
    string       name;
    logic [31:0] insn;
    logic        z;
    logic        l;
    logic        u;
    out_t        exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] insn;
  logic        alu_zero, alu_less, alu_uless;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  pc_src_t     pc_src;
  alu_src_a_t  alu_src_a;
  alu_src_b_t  alu_src_b;
  alu_op_t     alu_op;
  logic        reg_write;
  reg_wb_src_t reg_wb_src;
  mem_write_t  mem_write;
  mem_read_t   mem_read;
  logic        illegal;
  logic        illegal_seen;

  int checks = 0;
  int passes = 0;
  vec_t vecs[$];

  rv32i_ctrl_decode dut (
    .clk(clk), .rst(rst), .insn(insn),
    .alu_zero(alu_zero), .alu_less(alu_less), .alu_uless(alu_uless),
    .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .reg_write(reg_write), .reg_wb_src(reg_wb_src),
    .mem_write(mem_write), .mem_read(mem_read),
    .illegal(illegal), .illegal_seen(illegal_seen)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input string name, input logic [31:0] i,
                              input logic z, input logic l, input logic u,
                              input pc_src_t pc, input alu_src_a_t a, input alu_src_b_t b,
                              input alu_op_t op, input logic rw, input reg_wb_src_t wb,
                              input mem_write_t mw, input mem_read_t mr, input logic ill);
    vec_t v;
    v.name = name;
    v.insn = i;
    v.z = z;
    v.l = l;
    v.u = u;
    v.exp = '{pc_src: pc, a: a, b: b, op: op, rw: rw, wb: wb, mw: mw, mr: mr, ill: ill,
              opcode: i[6:0], funct3: i[14:12], funct7: i[31:25]};
    return v;
  endfunction

  function automatic vec_t mkIll(input string name, input logic [31:0] i);
    return mk(name, i, 1'b0, 1'b0, 1'b0, PC_SRC_PC4, ALU_SRC_A_RS1, ALU_SRC_B_RS2,
              ALU_OP_ADD, 1'b0, REG_WB_SRC_ALU, MEM_WRITE_NONE, MEM_READ_NONE, 1'b1);
  endfunction

  task automatic applyStimulus(input logic [31:0] i, input logic z, input logic l,
                               input logic u);
    @(negedge clk);
    insn      = i;
    alu_zero  = z;
    alu_less  = l;
    alu_uless = u;
    #1;
  endtask

  task automatic checkOutput(input string name, input out_t exp);
    out_t act;
    act = '{pc_src: pc_src, a: alu_src_a, b: alu_src_b, op: alu_op, rw: reg_write,
            wb: reg_wb_src, mw: mem_write, mr: mem_read, ill: illegal,
            opcode: opcode, funct3: funct3, funct7: funct7};
    checks++;
    if (act !== exp)
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    else
      passes++;
  endtask

  task automatic checkSeen(input string name, input logic exp);
    checks++;
    if (illegal_seen !== exp)
      $display("[TB] FAIL %s: illegal_seen got %b expected %b", name, illegal_seen, exp);
    else
      passes++;
  endtask

  initial begin
    rst = 1'b1;
    insn = 32'h0000_0013;
    alu_zero = 1'b0;
    alu_less = 1'b0;
    alu_uless = 1'b0;

    vecs.push_back(mk("addi", 32'h14d28393, 0,0,0, PC_SRC_PC4, ALU_SRC_A_RS1, ALU_SRC_B_IMM, ALU_OP_ADD, 1, REG_WB_SRC_ALU, MEM_WRITE_NONE, MEM_READ_NONE, 0));
    vecs.push_back(mk("xori", 32'hfd634f93, 0,0,0, PC_SRC_PC4, ALU_SRC_A_RS1, ALU_SRC_B_IMM, ALU_OP_XOR, 1, REG_WB_SRC_ALU, MEM_WRITE_NONE, MEM_READ_NONE, 0));
    vecs.push_back(mk("auipc", 32'h00309497, 0,0,0, PC_SRC_PC4, ALU_SRC_A_PC, ALU_SRC_B_IMM, ALU_OP_ADD, 1, REG_WB_SRC_ALU, MEM_WRITE_NONE, MEM_READ_NONE, 0));
    vecs.push_back(mk("lui", 32'hff806237, 0,0,0, PC_SRC_PC4, ALU_SRC_A_RS1, ALU_SRC_B_IMM, ALU_OP_COPY_B, 1, REG_WB_SRC_ALU, MEM_WRITE_NONE, MEM_READ_NONE, 0));
    vecs.push_back(mk("sw", 32'h14a0a0a3, 0,0,0, PC_SRC_PC4, ALU_SRC_A_RS1, ALU_SRC_B_IMM, ALU_OP_ADD, 0, REG_WB_SRC_ALU, MEM_WRITE_WORD, MEM_READ_NONE, 0));
    vecs.push_back(mk("sb", 32'h00000023, 0,0,0, PC_SRC_PC4, ALU_SRC_A_RS1, ALU_SRC_B_IMM, ALU_OP_ADD, 0, REG_WB_SRC_ALU, MEM_WRITE_BYTE, MEM_READ_NONE, 0));
    vecs.push_back(mk("jal", 32'h084003ef, 0,0,0, PC_SRC_ALU, ALU_SRC_A_PC, ALU_SRC_B_IMM, ALU_OP_ADD, 1, REG_WB_SRC_PC4, MEM_WRITE_NONE, MEM_READ_NONE, 0));
    vecs.push_back(mk("jalr", 32'h00008067, 0,0,0, PC_SRC_ALU, ALU_SRC_A_RS1, ALU_SRC_B_IMM, ALU_OP_ADD, 1, REG_WB_SRC_PC4, MEM_WRITE_NONE, MEM_READ_NONE, 0));
    vecs.push_back(mk("beq_taken", 32'h00208463, 1,0,0, PC_SRC_BRANCH, ALU_SRC_A_RS1, ALU_SRC_B_RS2, ALU_OP_SUB, 0, REG_WB_SRC_ALU, MEM_WRITE_NONE, MEM_READ_NONE, 0));
    vecs.push_back(mk("beq_not", 32'h00208463, 0,1,1, PC_SRC_PC4, ALU_SRC_A_RS1, ALU_SRC_B_RS2, ALU_OP_SUB, 0, REG_WB_SRC_ALU, MEM_WRITE_NONE, MEM_READ_NONE, 0));
    vecs.push_back(mk("bne_taken", 32'h00209463, 0,0,0, PC_SRC_BRANCH, ALU_SRC_A_RS1, ALU_SRC_B_RS2, ALU_OP_SUB, 0, REG_WB_SRC_ALU, MEM_WRITE_NONE, MEM_READ_NONE, 0));
    vecs.push_back(mk("blt_taken", 32'h0020c463, 0,1,0, PC_SRC_BRANCH, ALU_SRC_A_RS1, ALU_SRC_B_RS2, ALU_OP_SUB, 0, REG_WB_SRC_ALU, MEM_WRITE_NONE, MEM_READ_NONE, 0));
    vecs.push_back(mk("bge_not", 32'h0020d463, 0,1,0, PC_SRC_PC4, ALU_SRC_A_RS1, ALU_SRC_B_RS2, ALU_OP_SUB, 0, REG_WB_SRC_ALU, MEM_WRITE_NONE, MEM_READ_NONE, 0));
    vecs.push_back(mk("bltu_taken", 32'h0020e463, 0,0,1, PC_SRC_BRANCH, ALU_SRC_A_RS1, ALU_SRC_B_RS2, ALU_OP_SUB, 0, REG_WB_SRC_ALU, MEM_WRITE_NONE, MEM_READ_NONE, 0));
    vecs.push_back(mk("bgeu_taken", 32'h0020f463, 0,1,0, PC_SRC_BRANCH, ALU_SRC_A_RS1, ALU_SRC_B_RS2, ALU_OP_SUB, 0, REG_WB_SRC_ALU, MEM_WRITE_NONE, MEM_READ_NONE, 0));
    vecs.push_back(mk("add", 32'h00000033, 0,0,0, PC_SRC_PC4, ALU_SRC_A_RS1, ALU_SRC_B_RS2, ALU_OP_ADD, 1, REG_WB_SRC_ALU, MEM_WRITE_NONE, MEM_READ_NONE, 0));
    vecs.push_back(mk("sub", 32'h40000033, 0,0,0, PC_SRC_PC4, ALU_SRC_A_RS1, ALU_SRC_B_RS2, ALU_OP_SUB, 1, REG_WB_SRC_ALU, MEM_WRITE_NONE, MEM_READ_NONE, 0));
    vecs.push_back(mk("sra", 32'h40005033, 0,0,0, PC_SRC_PC4, ALU_SRC_A_RS1, ALU_SRC_B_RS2, ALU_OP_SRA, 1, REG_WB_SRC_ALU, MEM_WRITE_NONE, MEM_READ_NONE, 0));
    vecs.push_back(mk("sltu", 32'h00003033, 0,0,0, PC_SRC_PC4, ALU_SRC_A_RS1, ALU_SRC_B_RS2, ALU_OP_SLTU, 1, REG_WB_SRC_ALU, MEM_WRITE_NONE, MEM_READ_NONE, 0));
    vecs.push_back(mk("srai", 32'h40005013, 0,0,0, PC_SRC_PC4, ALU_SRC_A_RS1, ALU_SRC_B_IMM, ALU_OP_SRA, 1, REG_WB_SRC_ALU, MEM_WRITE_NONE, MEM_READ_NONE, 0));
    vecs.push_back(mk("srli", 32'h00005013, 0,0,0, PC_SRC_PC4, ALU_SRC_A_RS1, ALU_SRC_B_IMM, ALU_OP_SRL, 1, REG_WB_SRC_ALU, MEM_WRITE_NONE, MEM_READ_NONE, 0));
    vecs.push_back(mk("lw", 32'h00002003, 0,0,0, PC_SRC_PC4, ALU_SRC_A_RS1, ALU_SRC_B_IMM, ALU_OP_ADD, 1, REG_WB_SRC_MEM, MEM_WRITE_NONE, MEM_READ_WORD, 0));
    vecs.push_back(mk("lhu", 32'h00005003, 0,0,0, PC_SRC_PC4, ALU_SRC_A_RS1, ALU_SRC_B_IMM, ALU_OP_ADD, 1, REG_WB_SRC_MEM, MEM_WRITE_NONE, MEM_READ_HALF_U, 0));
    vecs.push_back(mk("fence", 32'h0000000f, 0,0,0, PC_SRC_PC4, ALU_SRC_A_RS1, ALU_SRC_B_RS2, ALU_OP_ADD, 0, REG_WB_SRC_ALU, MEM_WRITE_NONE, MEM_READ_NONE, 0));
    vecs.push_back(mk("ecall", 32'h00000073, 0,0,0, PC_SRC_PC4, ALU_SRC_A_RS1, ALU_SRC_B_RS2, ALU_OP_ADD, 0, REG_WB_SRC_ALU, MEM_WRITE_NONE, MEM_READ_NONE, 0));
    vecs.push_back(mkIll("all_ones", 32'hffffffff));
    vecs.push_back(mkIll("op_mul", 32'h02000033));
    vecs.push_back(mkIll("op_alt_and", 32'h40007033));
    vecs.push_back(mkIll("slli_f7", 32'h40001013));
    vecs.push_back(mkIll("load_f3_011", 32'h00003003));
    vecs.push_back(mkIll("jalr_f3_001", 32'h00009067));
    vecs.push_back(mkIll("branch_f3_010", 32'h0020a463));

    // Reset state and sticky-flag sequences.
    applyStimulus(32'hffffffff, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    checkSeen("reset_clears", 1'b0);
    rst = 1'b0;
    applyStimulus(32'h14d28393, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    checkSeen("legal_keeps_clear", 1'b0);
    applyStimulus(32'hffffffff, 1'b0, 1'b0, 1'b0);
    checkSeen("same_cycle_not_set", 1'b0);
    @(posedge clk);
    #1;
    checkSeen("set_after_illegal", 1'b1);
    applyStimulus(32'h14d28393, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    checkSeen("sticky_holds", 1'b1);
    applyStimulus(32'hffffffff, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkSeen("rst_beats_illegal", 1'b0);
    rst = 1'b0;
    applyStimulus(32'h00000033, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    checkSeen("stays_clear_after_rst", 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].insn, vecs[i].z, vecs[i].l, vecs[i].u);
      checkOutput(vecs[i].name, vecs[i].exp);
    end

    @(posedge clk);
    #1;
    checkSeen("set_by_table_illegal", 1'b1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
